// File: rtl/io_bus_master_pkg.sv
// Shared types and constants for the I/O bus initiator.
// Holds the FSM encoding and the bus geometry.
package io_bus_pkg;

  localparam int IO_ADDR_W = 17;
  localparam int IO_DATA_W = 32;

  localparam logic [IO_DATA_W-1:0] ERR_RDATA = '0;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_e;

endpackage

// File: rtl/io_bus_master_if.sv
// Command/response handshake plus Wishbone classic bus.
// master = initiator view, slave = requester/bus-side view.
interface io_bus_master_if #(
  parameter int ADDR_W = 17
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_adr;
  logic [31:0]       req_dat;
  logic [3:0]        req_sel;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_dat;
  logic              rsp_err;

  logic              cyc_o;
  logic              stb_o;
  logic              we_o;
  logic [ADDR_W-1:0] adr_o;
  logic [31:0]       dat_o;
  logic [3:0]        sel_o;
  logic [31:0]       dat_i;
  logic              ack_i;

  modport master (
    input  req_valid, req_we, req_adr,
    input  req_dat, req_sel,
    output req_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output cyc_o, stb_o, we_o, adr_o,
    output dat_o, sel_o,
    input  dat_i, ack_i
  );

  modport slave (
    output req_valid, req_we, req_adr,
    output req_dat, req_sel,
    input  req_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  cyc_o, stb_o, we_o, adr_o,
    input  dat_o, sel_o,
    output dat_i, ack_i
  );

endinterface

// File: rtl/io_bus_master.sv
// Single-outstanding Wishbone classic initiator with an
// ack watchdog that turns a silent slave into an error.
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int ADDR_W  = IO_ADDR_W,
  parameter int TIMEOUT = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  io_bus_master_if.master bus,
  output logic         busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT);

  state_e                 state_q;
  logic [TW-1:0]          timer_q;
  logic                   cyc_q;
  logic                   stb_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      adr_q;
  logic [IO_DATA_W-1:0]   dat_q;
  logic [3:0]             sel_q;
  logic                   rsp_valid_q;
  logic                   rsp_err_q;
  logic [IO_DATA_W-1:0]   rsp_dat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            adr_q   <= bus.req_adr;
            dat_q   <= bus.req_dat;
            sel_q   <= bus.req_sel;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            timer_q <= '0;
            state_q <= BUS;
          end
        end
        BUS: begin
          // ack outranks a coinciding timeout
          if (bus.ack_i) begin
            rsp_dat_q   <= we_q ? '0 : bus.dat_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            state_q     <= RESP;
          end else if (timer_q == T_LAST) begin
            rsp_dat_q   <= ERR_RDATA;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            state_q     <= RESP;
          end else if (timer_q != T_SAT) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);

  assign bus.cyc_o     = cyc_q;
  assign bus.stb_o     = stb_q;
  assign bus.we_o      = we_q;
  assign bus.adr_o     = adr_q;
  assign bus.dat_o     = dat_q;
  assign bus.sel_o     = sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_dat   = rsp_dat_q;

endmodule
